// File: rtl/tile_storer_if.sv
// Port bundle between tile_storer and its neighbours: orchestrator, write-side
// address generator, dma_write and the C result buffer.
interface tile_storer_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int C_ADDR_W = 14
);
    logic                st_req;
    logic [31:0]         rows;
    logic [31:0]         cols;
    logic [ADDR_W-1:0]   base_C;
    logic [31:0]         stride_C;

    logic                ag_start;
    logic [31:0]         ag_base_addr;
    logic [31:0]         ag_bytes_total;
    logic                ag_req_valid;
    logic                ag_req_ready;
    logic [ADDR_W-1:0]   ag_req_addr;
    logic [7:0]          ag_req_len;
    logic                ag_req_last;
    logic                ag_done;

    logic                wr_start_dma;
    logic [ADDR_W-1:0]   wr_start_addr;
    logic [7:0]          wr_num_trans;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_data_vld;
    logic                wr_data_rdy;
    logic                wr_done;

    logic                c_re;
    logic [C_ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0]   c_rdata;
    logic                st_done;

    modport slave (
        input  st_req, rows, cols, base_C, stride_C,
        input  ag_req_valid, ag_req_addr, ag_req_len, ag_req_last, ag_done,
        input  wr_data_rdy, wr_done, c_rdata,
        output ag_start, ag_base_addr, ag_bytes_total, ag_req_ready,
        output wr_start_dma, wr_start_addr, wr_num_trans, wr_data, wr_data_vld,
        output c_re, c_addr, st_done
    );

    modport master (
        output st_req, rows, cols, base_C, stride_C,
        output ag_req_valid, ag_req_addr, ag_req_len, ag_req_last, ag_done,
        output wr_data_rdy, wr_done, c_rdata,
        input  ag_start, ag_base_addr, ag_bytes_total, ag_req_ready,
        input  wr_start_dma, wr_start_addr, wr_num_trans, wr_data, wr_data_vld,
        input  c_re, c_addr, st_done
    );
endinterface

// File: rtl/tile_storer.sv
// Drains one C tile from the result buffer to DDR row by row, one write burst
// in flight at a time, with beat data staged through a 2-entry prefetch FIFO.
module tile_storer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int C_ADDR_W = 14
) (
    input  logic          clk,
    input  logic          rst,
    tile_storer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ROW_LAUNCH, ROW_RUN, ROW_WAIT, DONE} state_t;

    state_t              state_q;
    logic [31:0]         rows_q, cols_q, strideC_q, total_q;
    logic [ADDR_W-1:0]   baseC_q;
    logic [31:0]         row_q, rdIdx_q, wordSent_q;
    logic                inflight_q, lastSeen_q, agDoneSeen_q;
    logic [8:0]          burstLeft_q, fetchLeft_q;
    logic                cRe_q, rVld_q;
    logic [C_ADDR_W-1:0] cAddr_q;
    logic [DATA_W-1:0]   fifoMem_q [2];
    logic                fifoRd_q, fifoWr_q;
    logic [1:0]          fifoCnt_q, fifoCnt_d;
    logic                agStart_q, wrStart_q, stDone_q;
    logic [31:0]         agBase_q, agBytes_q;
    logic [ADDR_W-1:0]   wrAddr_q;
    logic [7:0]          wrNum_q;

    logic                accept, pop, push, issueRd, beatVld;
    logic [2:0]          occupancy;

    // Reads already launched count against FIFO space so it can never overflow.
    always_comb begin
        accept    = (state_q == ROW_RUN) && bus.ag_req_valid && !inflight_q;
        beatVld   = (fifoCnt_q != 2'd0) && (burstLeft_q != 9'd0);
        pop       = beatVld && bus.wr_data_rdy;
        push      = rVld_q;
        occupancy = {1'b0, fifoCnt_q} + {2'b00, cRe_q} + {2'b00, rVld_q};
        issueRd   = (state_q == ROW_RUN) && (fetchLeft_q != 9'd0) &&
                    (occupancy < 3'd2) && (rdIdx_q < total_q);
        fifoCnt_d = fifoCnt_q;
        if (push && !pop) begin
            fifoCnt_d = fifoCnt_q + 2'd1;
        end else if (pop && !push) begin
            fifoCnt_d = fifoCnt_q - 2'd1;
        end
    end

    assign bus.ag_start       = agStart_q;
    assign bus.ag_base_addr   = agBase_q;
    assign bus.ag_bytes_total = agBytes_q;
    assign bus.ag_req_ready   = accept;
    assign bus.wr_start_dma   = wrStart_q;
    assign bus.wr_start_addr  = wrAddr_q;
    assign bus.wr_num_trans   = wrNum_q;
    assign bus.wr_data        = fifoMem_q[fifoRd_q];
    assign bus.wr_data_vld    = beatVld;
    assign bus.c_re           = cRe_q;
    assign bus.c_addr         = cAddr_q;
    assign bus.st_done        = stDone_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            strideC_q    <= '0;
            total_q      <= '0;
            baseC_q      <= '0;
            row_q        <= '0;
            rdIdx_q      <= '0;
            wordSent_q   <= '0;
            inflight_q   <= 1'b0;
            lastSeen_q   <= 1'b0;
            agDoneSeen_q <= 1'b0;
            burstLeft_q  <= '0;
            fetchLeft_q  <= '0;
            cRe_q        <= 1'b0;
            rVld_q       <= 1'b0;
            cAddr_q      <= '0;
            fifoMem_q[0] <= '0;
            fifoMem_q[1] <= '0;
            fifoRd_q     <= 1'b0;
            fifoWr_q     <= 1'b0;
            fifoCnt_q    <= '0;
            agStart_q    <= 1'b0;
            agBase_q     <= '0;
            agBytes_q    <= '0;
            wrStart_q    <= 1'b0;
            wrAddr_q     <= '0;
            wrNum_q      <= '0;
            stDone_q     <= 1'b0;
        end else begin
            agStart_q <= 1'b0;
            wrStart_q <= 1'b0;
            stDone_q  <= 1'b0;
            cRe_q     <= issueRd;
            rVld_q    <= cRe_q;
            fifoCnt_q <= fifoCnt_d;

            if (issueRd) begin
                cAddr_q     <= rdIdx_q[C_ADDR_W-1:0];
                rdIdx_q     <= rdIdx_q + 32'd1;
                fetchLeft_q <= fetchLeft_q - 9'd1;
            end
            if (push) begin
                fifoMem_q[fifoWr_q] <= bus.c_rdata;
                fifoWr_q            <= ~fifoWr_q;
            end
            if (pop) begin
                fifoRd_q    <= ~fifoRd_q;
                burstLeft_q <= burstLeft_q - 9'd1;
                wordSent_q  <= wordSent_q + 32'd1;
            end

            // A new burst is only accepted once the previous one has been acknowledged.
            if (accept) begin
                inflight_q  <= 1'b1;
                wrStart_q   <= 1'b1;
                wrAddr_q    <= bus.ag_req_addr;
                wrNum_q     <= bus.ag_req_len + 8'd1;
                burstLeft_q <= {1'b0, bus.ag_req_len} + 9'd1;
                fetchLeft_q <= {1'b0, bus.ag_req_len} + 9'd1;
                lastSeen_q  <= bus.ag_req_last;
            end else if (bus.wr_done) begin
                inflight_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.st_req) begin
                        rows_q    <= bus.rows;
                        cols_q    <= bus.cols;
                        baseC_q   <= bus.base_C;
                        strideC_q <= bus.stride_C;
                        total_q   <= bus.rows * bus.cols;
                        row_q     <= '0;
                        rdIdx_q   <= '0;
                        state_q   <= (bus.rows == 32'd0 || bus.cols == 32'd0) ? DONE : ROW_LAUNCH;
                    end
                end
                ROW_LAUNCH: begin
                    agStart_q    <= 1'b1;
                    agBase_q     <= 32'(baseC_q) + row_q * strideC_q;
                    agBytes_q    <= cols_q << 2;
                    wordSent_q   <= '0;
                    lastSeen_q   <= 1'b0;
                    agDoneSeen_q <= 1'b0;
                    state_q      <= ROW_RUN;
                end
                ROW_RUN: begin
                    if (bus.ag_done) agDoneSeen_q <= 1'b1;
                    if (wordSent_q == cols_q) state_q <= ROW_WAIT;
                end
                ROW_WAIT: begin
                    if (bus.ag_done) agDoneSeen_q <= 1'b1;
                    // Either completion may have been seen earlier; both must be in before moving on.
                    if (lastSeen_q && (!inflight_q || bus.wr_done) &&
                        (agDoneSeen_q || bus.ag_done)) begin
                        row_q   <= row_q + 32'd1;
                        state_q <= (row_q + 32'd1 == rows_q) ? DONE : ROW_LAUNCH;
                    end
                end
                DONE: begin
                    stDone_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_storer.sv
// Scoreboard bench for tile_storer with behavioural address generator,
// dma_write and C buffer models around it.
module tb_tile_storer;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int C_ADDR_W = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tile_storer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .C_ADDR_W(C_ADDR_W)) bus ();

    tile_storer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .C_ADDR_W(C_ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    int checkCount = 0;
    int passCount  = 0;

    logic [63:0] expAg[$];
    logic [39:0] expWr[$];
    logic [31:0] expBeat[$];
    logic [40:0] genQ[$];

    int numLens = 1;
    int lensA[2];
    bit toggleRdy = 1'b0;

    int  reqCycle = 0;
    bit  firstAgPending = 1'b0;
    bit  zeroLatPending = 1'b0;
    int  expWrDones = 0;
    int  doneCount = 0;
    int  wrDoneCount = 0;
    int  creCount = 0;
    int  beatCount = 0;
    int  grantedBeats = 0;
    int  dmaLeftMon = 0;
    int  expCAddr = 0;
    bit  inflightMon = 1'b0;
    bit  prevWrDone = 1'b0;

    function automatic logic [31:0] cData(input int idx);
        return 32'hC0DE0000 + 32'(idx) * 32'd17 + 32'd5;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic resetScoreboard();
        expAg.delete();
        expWr.delete();
        expBeat.delete();
        firstAgPending = 1'b0;
        zeroLatPending = 1'b0;
        expWrDones     = 0;
        doneCount      = 0;
        wrDoneCount    = 0;
        creCount       = 0;
        beatCount      = 0;
        grantedBeats   = 0;
        dmaLeftMon     = 0;
        expCAddr       = 0;
        inflightMon    = 1'b0;
        prevWrDone     = 1'b0;
    endtask

    // Expected traffic for the whole tile is queued before the request goes out.
    task automatic applyStimulus(input int r, input int c, input logic [31:0] base,
                                 input logic [31:0] stride, input int nl, input int l0,
                                 input int l1, input bit tog);
        logic [31:0] rowBase, addr;
        resetScoreboard();
        numLens   = nl;
        lensA[0]  = l0;
        lensA[1]  = l1;
        toggleRdy = tog;
        for (int row = 0; row < r && c != 0; row++) begin
            rowBase = base + 32'(row) * stride;
            expAg.push_back({rowBase, 32'(c * 4)});
            addr = rowBase;
            for (int k = 0; k < nl; k++) begin
                expWr.push_back({addr, 8'(lensA[k] + 1)});
                addr = addr + 32'((lensA[k] + 1) * 4);
            end
        end
        for (int i = 0; i < r * c; i++) expBeat.push_back(cData(i));
        expWrDones     = (r == 0 || c == 0) ? 0 : r * nl;
        firstAgPending = (r != 0 && c != 0);
        zeroLatPending = !firstAgPending;
        @(posedge clk);
        #1;
        bus.rows     = 32'(r);
        bus.cols     = 32'(c);
        bus.base_C   = base;
        bus.stride_C = stride;
        bus.st_req   = 1'b1;
        reqCycle     = cycleCnt;
        @(posedge clk);
        #1;
        bus.st_req = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (doneCount == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("stDoneSeen", doneCount > 0, 1);
        repeat (20) @(posedge clk);
        #3;
        checkOutput("stDoneOnce", doneCount, 1);
        checkOutput("agLeftover", expAg.size(), 0);
        checkOutput("wrLeftover", expWr.size(), 0);
        checkOutput("beatLeftover", expBeat.size(), 0);
    endtask

    function automatic bit outputsNonZero();
        return |{bus.ag_start, bus.ag_base_addr, bus.ag_bytes_total, bus.ag_req_ready,
                 bus.wr_start_dma, bus.wr_start_addr, bus.wr_num_trans, bus.wr_data,
                 bus.wr_data_vld, bus.c_re, bus.c_addr, bus.st_done};
    endfunction

    // Environment: address generator, dma_write and C buffer read port.
    initial begin
        bit sAcc, sBeat, sStart, sDma, sCre;
        logic [31:0] sBase, gAddr;
        logic [7:0] sNum;
        logic [C_ADDR_W-1:0] sCaddr;
        logic [40:0] item;
        int beatsLeft = 0, doneTimer = 0, agDoneTimer = 0;
        bus.ag_req_valid = 1'b0;
        bus.ag_req_addr  = '0;
        bus.ag_req_len   = '0;
        bus.ag_req_last  = 1'b0;
        bus.ag_done      = 1'b0;
        bus.wr_data_rdy  = 1'b1;
        bus.wr_done      = 1'b0;
        bus.c_rdata      = '0;
        forever begin
            @(negedge clk);
            sAcc   = bus.ag_req_valid && bus.ag_req_ready;
            sBeat  = bus.wr_data_vld && bus.wr_data_rdy;
            sStart = bus.ag_start;
            sBase  = bus.ag_base_addr;
            sDma   = bus.wr_start_dma;
            sNum   = bus.wr_num_trans;
            sCre   = bus.c_re;
            sCaddr = bus.c_addr;
            @(posedge clk);
            #1;
            bus.wr_done = 1'b0;
            bus.ag_done = 1'b0;
            bus.c_rdata = sCre ? cData(int'(sCaddr)) : 32'hDEADBEEF;
            if (rst) begin
                genQ.delete();
                beatsLeft   = 0;
                doneTimer   = 0;
                agDoneTimer = 0;
                bus.wr_data_rdy = 1'b1;
            end else begin
                if (agDoneTimer > 0) begin
                    agDoneTimer--;
                    if (agDoneTimer == 0) bus.ag_done = 1'b1;
                end
                if (sStart) begin
                    gAddr = sBase;
                    for (int k = 0; k < numLens; k++) begin
                        genQ.push_back({(k == numLens - 1), 8'(lensA[k]), gAddr});
                        gAddr = gAddr + 32'((lensA[k] + 1) * 4);
                    end
                end
                if (sAcc && genQ.size() > 0) begin
                    item = genQ.pop_front();
                    if (item[40]) agDoneTimer = 2;
                end
                if (doneTimer > 0) begin
                    doneTimer--;
                    if (doneTimer == 0) bus.wr_done = 1'b1;
                end
                if (sDma) beatsLeft = int'(sNum);
                if (sBeat && beatsLeft > 0) begin
                    beatsLeft--;
                    if (beatsLeft == 0) doneTimer = 3;
                end
                bus.wr_data_rdy = toggleRdy ? ~bus.wr_data_rdy : 1'b1;
            end
            bus.ag_req_valid = (genQ.size() > 0);
            if (genQ.size() > 0) begin
                bus.ag_req_addr = genQ[0][31:0];
                bus.ag_req_len  = genQ[0][39:32];
                bus.ag_req_last = genQ[0][40];
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    initial begin
        logic [63:0] eAg;
        logic [39:0] eWr;
        logic [31:0] eBeat;
        forever begin
            @(negedge clk);
            if (bus.ag_start) begin
                if (firstAgPending) begin
                    checkOutput("agStartLatency", cycleCnt - reqCycle, 2);
                    firstAgPending = 1'b0;
                end
                checkOutput("agStartExpected", expAg.size() > 0, 1);
                if (expAg.size() > 0) begin
                    eAg = expAg.pop_front();
                    checkOutput("agBase", bus.ag_base_addr, eAg[63:32]);
                    checkOutput("agBytes", bus.ag_bytes_total, eAg[31:0]);
                end
            end
            if (bus.wr_start_dma) begin
                inflightMon  = 1'b1;
                dmaLeftMon   = int'(bus.wr_num_trans);
                grantedBeats = grantedBeats + int'(bus.wr_num_trans);
                checkOutput("wrStartExpected", expWr.size() > 0, 1);
                if (expWr.size() > 0) begin
                    eWr = expWr.pop_front();
                    checkOutput("wrAddr", bus.wr_start_addr, eWr[39:8]);
                    checkOutput("wrNum", bus.wr_num_trans, eWr[7:0]);
                end
            end
            if (bus.ag_req_ready) checkOutput("readyWhileInflight", inflightMon, 0);
            if (prevWrDone && bus.ag_req_valid) checkOutput("readyAfterDone", bus.ag_req_ready, 1);
            if (bus.c_re) begin
                creCount++;
                checkOutput("cAddr", bus.c_addr, 64'(expCAddr));
                expCAddr++;
                checkOutput("readWithinBurst", creCount <= grantedBeats, 1);
                checkOutput("readAhead", (creCount - beatCount) <= 2, 1);
            end
            if (bus.wr_data_vld && bus.wr_data_rdy) begin
                checkOutput("beatWithinBurst", dmaLeftMon > 0, 1);
                dmaLeftMon--;
                beatCount++;
                checkOutput("beatExpected", expBeat.size() > 0, 1);
                if (expBeat.size() > 0) begin
                    eBeat = expBeat.pop_front();
                    checkOutput("beatData", bus.wr_data, eBeat);
                end
            end
            if (bus.wr_done) begin
                inflightMon = 1'b0;
                wrDoneCount++;
            end
            prevWrDone = bus.wr_done;
            if (bus.st_done) begin
                doneCount++;
                if (zeroLatPending) checkOutput("stDoneLatency", cycleCnt - reqCycle, 2);
                checkOutput("stDoneAfterWrDone", wrDoneCount, expWrDones);
            end
        end
    end

    initial begin
        int n;
        bus.st_req   = 1'b0;
        bus.rows     = '0;
        bus.cols     = '0;
        bus.base_C   = '0;
        bus.stride_C = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("powerOnReset", outputsNonZero(), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] two rows, one burst per row");
        applyStimulus(2, 8, 32'h1000, 32'd64, 1, 7, 0, 1'b0);
        waitDone();

        $display("[TB] one row split into two bursts, toggling ready");
        applyStimulus(1, 20, 32'h2000, 32'h100, 2, 15, 3, 1'b1);
        waitDone();

        $display("[TB] zero-row tile");
        applyStimulus(0, 5, 32'h3000, 32'd64, 1, 4, 0, 1'b0);
        waitDone();

        $display("[TB] reset in the middle of a burst");
        applyStimulus(1, 8, 32'h3000, 32'd64, 1, 7, 0, 1'b0);
        n = 0;
        while (beatCount < 3 && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput("midBurstReached", beatCount >= 3, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("resetOutputs", outputsNonZero(), 0);
        resetScoreboard();
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] restart after reset with a stray st_req while running");
        applyStimulus(1, 4, 32'h4000, 32'd64, 1, 3, 0, 1'b0);
        n = 0;
        while (expAg.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checkOutput("restartAgStart", expAg.size(), 0);
        @(posedge clk);
        #1;
        bus.rows   = 32'd0;
        bus.st_req = 1'b1;
        @(posedge clk);
        #1;
        bus.st_req = 1'b0;
        waitDone();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
